// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request scheduler and its
// companion blocks: FSM state encoding, default width, one-hot utilities.
package rr_pkg;

  localparam int DEFAULT_WIDTH = 8;
  // Widest vector the helper functions accept; narrower vectors are zero-extended.
  localparam int MAX_WIDTH     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rr_state_t;

  // True when exactly one bit of vec is set.
  function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_WIDTH'(1))) == '0);
  endfunction

  // Bit position of a one-hot vector; highest set bit wins if it is not one-hot.
  function automatic int idx_of(input logic [MAX_WIDTH-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_request_scheduler_if.sv
// Handshake bundle between the request scheduler, its clients, the pair of
// priority arbiters and the downstream grant consumer.
// slave  : the scheduler side.
// master : the client / arbiter / consumer side.
interface rr_request_scheduler_if #(
  parameter int WIDTH = rr_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] req_in;
  logic [WIDTH-1:0] request;
  logic [WIDTH-1:0] masked_request;
  logic [WIDTH-1:0] unmasked_grant;
  logic [WIDTH-1:0] masked_grant;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic             grant_ready;
  logic             grant_err;
  logic             timeout;

  modport slave (
    input  req_in, unmasked_grant, masked_grant, grant_ready,
    output request, masked_request, grant, grant_valid, grant_err, timeout
  );

  modport master (
    output req_in, unmasked_grant, masked_grant, grant_ready,
    input  request, masked_request, grant, grant_valid, grant_err, timeout
  );
endinterface

// File: rtl/rr_mask_gen.sv
// Round-robin mask generator: given the one-hot vector just granted, keeps
// only the positions strictly above it eligible for the masked arbiter.
// A grant at the top position yields an empty mask (wrap-around).
module rr_mask_gen
  import rr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] grant_oh,
  output logic [WIDTH-1:0] mask_next
);

  // (grant << 1) - 1 covers bits 0..k; its complement is everything above k.
  always_comb begin
    mask_next = ~((grant_oh << 1) - WIDTH'(1));
  end

endmodule

// File: rtl/rr_request_scheduler.sv
// Requester side of a round-robin arbitration pair. Latches client request
// pulses into a pending vector, presents unmasked and masked request vectors
// to two lowest-index-first arbiters, validates the returned grant, holds it
// until downstream accepts, then retires the request and rotates the mask.
// Optional feature macro: RR_GRANT_TIMEOUT_EN (drops a grant that waits
// TIMEOUT cycles for grant_ready and moves on to the next client).
module rr_request_scheduler
  import rr_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  rr_request_scheduler_if.slave bus
);

  rr_state_t        state, state_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic [WIDTH-1:0] mask, mask_n;
  logic [WIDTH-1:0] grant, grant_n;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] mask_adv;
  logic             grant_valid, grant_valid_n;
  logic             grant_err, grant_err_n;
  logic             sel_legal;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             timeout, timeout_n;
  assign bus.timeout = timeout;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign bus.timeout        = 1'b0;
`endif

  assign bus.request        = pending;
  assign bus.masked_request = pending & mask;
  assign bus.grant          = grant;
  assign bus.grant_valid    = grant_valid;
  assign bus.grant_err      = grant_err;

  // Prefer the masked arbiter while anything above the last grant is pending.
  assign sel       = (|(pending & mask)) ? bus.masked_grant : bus.unmasked_grant;
  assign sel_legal = is_onehot(MAX_WIDTH'(sel)) && (|(sel & pending));

  rr_mask_gen #(.WIDTH(WIDTH)) u_mask_gen (
    .grant_oh  (grant),
    .mask_next (mask_adv)
  );

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      mask        <= '1;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_err   <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt         <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      mask        <= mask_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_err   <= grant_err_n;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt         <= cnt_n;
      timeout     <= timeout_n;
`endif
    end
  end

  // Next-state, grant capture, retirement and pending update.
  always_comb begin
    state_n       = state;
    mask_n        = mask;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_err_n   = 1'b0;
    clr           = '0;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_n         = cnt;
    timeout_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|pending) begin
          if (sel_legal) begin
            grant_n       = sel;
            grant_valid_n = 1'b1;
            state_n       = HOLD;
`ifdef RR_GRANT_TIMEOUT_EN
            cnt_n         = '0;
`endif
          end else begin
            // Bad arbiter answer: flag it and retry next cycle, mask untouched.
            grant_err_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.grant_ready) begin
          clr           = grant;
          mask_n        = mask_adv;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          state_n       = IDLE;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // Stalled consumer: keep the request pending but rotate past it.
          timeout_n     = 1'b1;
          mask_n        = mask_adv;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          state_n       = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    // A new request on the bit being retired wins and stays queued.
    pending_n = (pending & ~clr) | bus.req_in;
  end

endmodule

// File: tb/tb_rr_request_scheduler.sv
// Self-checking bench for rr_request_scheduler. The two priority arbiters
// are modelled here; expectations come from a pointer-based round-robin
// reference model.
module tb_rr_request_scheduler;

  localparam int W = 8;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam int TMO     = 4;
  localparam int BP_HOLD = 2;
`else
  localparam int TMO     = 16;
  localparam int BP_HOLD = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_request_scheduler_if #(.WIDTH(W)) bus ();

  rr_request_scheduler #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Arbiter override: both arbiters return ovr_vec while ovr_en is set.
  logic         ovr_en  = 1'b0;
  logic [W-1:0] ovr_vec = '0;

  function automatic logic [W-1:0] lowest(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) begin
      if (v[i]) return W'(1) << i;
    end
    return '0;
  endfunction

  always_comb begin
    bus.unmasked_grant = ovr_en ? ovr_vec : lowest(bus.request);
    bus.masked_grant   = ovr_en ? ovr_vec : lowest(bus.masked_request);
  end

  // Reference model: pending set, index of the last retired client, hold flag.
  logic [W-1:0] m_pend;
  bit           m_hold, m_err, m_tmo;
  int           m_g, m_last, m_cnt;

  function automatic logic [W-1:0] mask_of(input int last);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = (i > last);
    return m;
  endfunction

  function automatic int rr_pick(input logic [W-1:0] pend, input int last);
    for (int i = last + 1; i < W; i++) if (pend[i]) return i;
    for (int i = 0; i < W; i++) if (pend[i]) return i;
    return 0;
  endfunction

  function automatic logic [3*W+2:0] exp_vec();
    logic [W-1:0] g;
    g = m_hold ? (W'(1) << m_g) : '0;
    return {g, m_hold, m_err, m_tmo, m_pend, m_pend & mask_of(m_last)};
  endfunction

  function automatic logic [3*W+2:0] act_vec();
    return {bus.grant, bus.grant_valid, bus.grant_err, bus.timeout,
            bus.request, bus.masked_request};
  endfunction

  task automatic model_clear();
    m_pend = '0; m_hold = 0; m_g = 0; m_last = -1;
    m_err = 0; m_tmo = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req_in = '0; bus.grant_ready = 1'b0; ovr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one cycle of inputs, advance the model, land 1 time unit past the edge.
  task automatic step(input logic [W-1:0] req, input bit ready);
    logic [W-1:0] n_pend;
    bit           n_hold, n_err, n_tmo;
    int           n_g, n_last, n_cnt;
    bus.req_in = req; bus.grant_ready = ready;
    n_pend = m_pend; n_hold = m_hold; n_g = m_g; n_last = m_last;
    n_err = 0; n_tmo = 0; n_cnt = m_cnt;
    if (!m_hold) begin
      if (m_pend != '0) begin
        if (ovr_en) begin
          if ($countones(ovr_vec) == 1 && (ovr_vec & m_pend) != '0) begin
            n_hold = 1; n_cnt = 0;
            for (int i = 0; i < W; i++) if (ovr_vec[i]) n_g = i;
          end else begin
            n_err = 1;
          end
        end else begin
          n_hold = 1; n_cnt = 0; n_g = rr_pick(m_pend, m_last);
        end
      end
    end else begin
      if (ready) begin
        n_pend[m_g] = 1'b0; n_last = m_g; n_hold = 0;
      end
`ifdef RR_GRANT_TIMEOUT_EN
      else if (m_cnt == TMO - 1) begin
        n_tmo = 1; n_last = m_g; n_hold = 0;
      end else begin
        n_cnt = m_cnt + 1;
      end
`endif
    end
    n_pend = n_pend | req;
    @(posedge clk);
    #1;
    m_pend = n_pend; m_hold = n_hold; m_g = n_g; m_last = n_last;
    m_err = n_err; m_tmo = n_tmo; m_cnt = n_cnt;
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (m_pend == '0 && !m_hold) break;
      step('0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_in = '1; bus.grant_ready = 1'b1; ovr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", act_vec());
    end
    rst = 1'b0; bus.req_in = '0;
    model_clear();
    step('0, 1'b0);
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_grant();
    do_reset();
    step(8'b0000_0100, 1'b1);
    checks++;
    if (bus.request !== 8'b0000_0100 || bus.grant_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pending: request %b valid %b expected 00000100 0", bus.request, bus.grant_valid);
    end
    step('0, 1'b1);
    checks++;
    if (bus.grant !== 8'b0000_0100 || bus.grant_valid !== 1'b1) begin
      errors++; $display("FAIL basic_grant: grant %b valid %b expected 00000100 1", bus.grant, bus.grant_valid);
    end
    step('0, 1'b1);
    checks++;
    if (bus.grant !== '0 || bus.grant_valid !== 1'b0 || bus.request !== '0) begin
      errors++; $display("FAIL basic_retire: grant %b valid %b request %b expected 0", bus.grant, bus.grant_valid, bus.request);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (bus.masked_request !== 8'b1111_1000) begin
      errors++; $display("FAIL basic_mask: masked_request %b expected 11111000", bus.masked_request);
    end
    step('0, 1'b1);
    checks++;
    if (bus.grant !== 8'b0000_1000) begin
      errors++; $display("FAIL basic_next: grant %b expected 00001000", bus.grant);
    end
    drain();
  endtask

  task automatic test_rotation();
    logic [W-1:0] got[$];
    logic [W-1:0] want[3];
    want[0] = 8'b0000_0001; want[1] = 8'b0000_0100; want[2] = 8'b1000_0000;
    do_reset();
    step(8'b1000_0101, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (bus.grant_valid) got.push_back(bus.grant);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rotation_cycle%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      step('0, 1'b1);
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL rotation_count: got %0d grants expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL rotation_order%0d: got %b expected %b", i, got[i], want[i]);
        end
      end
    end
    step(8'b0000_0001, 1'b1);
    checks++;
    if (bus.masked_request !== '0 || bus.request !== 8'b0000_0001) begin
      errors++; $display("FAIL rotation_wrap_mask: masked %b request %b expected 00000000 00000001", bus.masked_request, bus.request);
    end
    step('0, 1'b1);
    checks++;
    if (bus.grant !== 8'b0000_0001) begin
      errors++; $display("FAIL rotation_wrap_grant: grant %b expected 00000001", bus.grant);
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    step(8'b0000_0010, 1'b0);
    step('0, 1'b0);
    for (int i = 0; i <= BP_HOLD; i++) begin
      checks++;
      if (bus.grant !== 8'b0000_0010 || bus.grant_valid !== 1'b1 || bus.request !== 8'b0000_0010) begin
        errors++; $display("FAIL backpressure_hold%0d: grant %b valid %b request %b expected 00000010 1 00000010", i, bus.grant, bus.grant_valid, bus.request);
      end
      step('0, i == BP_HOLD);
    end
    checks++;
    if (bus.grant !== '0 || bus.grant_valid !== 1'b0 || bus.request !== '0) begin
      errors++; $display("FAIL backpressure_retire: grant %b valid %b request %b expected 0", bus.grant, bus.grant_valid, bus.request);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (bus.masked_request !== 8'b1111_1100) begin
      errors++; $display("FAIL backpressure_mask: masked %b expected 11111100", bus.masked_request);
    end
    drain();
  endtask

  task automatic test_collision();
    logic [W-1:0] got[$];
    logic [W-1:0] want[4];
    bit           injected;
    logic [W-1:0] req;
    want[0] = 8'b0000_0010; want[1] = 8'b0000_1000;
    want[2] = 8'b0100_0000; want[3] = 8'b0000_1000;
    injected = 0;
    do_reset();
    step(8'b0100_1010, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (bus.grant_valid) got.push_back(bus.grant);
      req = '0;
      if (m_hold && m_g == 3 && !injected) req = 8'b0000_1000;
      step(req, 1'b1);
      if (req != '0) begin
        injected = 1;
        checks++;
        if (bus.request[3] !== 1'b1) begin
          errors++; $display("FAIL collision_keep: request %b expected bit3 set", bus.request);
        end
      end
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL collision_count: got %0d grants expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL collision_order%0d: got %b expected %b", i, got[i], want[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_illegal();
    do_reset();
    ovr_en = 1'b1; ovr_vec = 8'b0000_0110;
    step(8'b0000_0010, 1'b0);
    step('0, 1'b0);
    checks++;
    if (bus.grant_err !== 1'b1 || bus.grant !== '0 || bus.grant_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_multihot: err %b grant %b valid %b expected 1 0 0", bus.grant_err, bus.grant, bus.grant_valid);
    end
    ovr_vec = 8'b0001_0000;
    step('0, 1'b0);
    checks++;
    if (bus.grant_err !== 1'b1 || bus.grant !== '0 || bus.masked_request !== 8'b0000_0010) begin
      errors++; $display("FAIL illegal_nonpending: err %b grant %b masked %b expected 1 0 00000010", bus.grant_err, bus.grant, bus.masked_request);
    end
    ovr_en = 1'b0;
    step('0, 1'b0);
    checks++;
    if (bus.grant_err !== 1'b0 || bus.grant !== 8'b0000_0010) begin
      errors++; $display("FAIL illegal_recover: err %b grant %b expected 0 00000010", bus.grant_err, bus.grant);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL illegal_model: got %h expected %h", act_vec(), exp_vec());
    end
    drain();
  endtask

`ifdef RR_GRANT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    step(8'b0000_0110, 1'b0);
    step('0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step('0, 1'b0);
      if (i < 4) begin
        checks++;
        if (bus.grant !== 8'b0000_0010 || bus.timeout !== 1'b0) begin
          errors++; $display("FAIL timeout_hold%0d: grant %b timeout %b expected 00000010 0", i, bus.grant, bus.timeout);
        end
      end
    end
    checks++;
    if (bus.timeout !== 1'b1 || bus.grant !== '0 || bus.request !== 8'b0000_0110) begin
      errors++; $display("FAIL timeout_fire: timeout %b grant %b request %b expected 1 0 00000110", bus.timeout, bus.grant, bus.request);
    end
    step('0, 1'b1);
    checks++;
    if (bus.timeout !== 1'b0 || bus.grant !== 8'b0000_0100) begin
      errors++; $display("FAIL timeout_next: timeout %b grant %b expected 0 00000100", bus.timeout, bus.grant);
    end
    drain();
  endtask
`endif

  task automatic test_reset_mid_hold();
    do_reset();
    step(8'b0011_0000, 1'b0);
    step('0, 1'b0);
    checks++;
    if (bus.grant !== 8'b0001_0000) begin
      errors++; $display("FAIL midhold_setup: grant %b expected 00010000", bus.grant);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("FAIL midhold_reset: got %h expected 0", act_vec());
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    logic [W-1:0] req;
    bit           rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      rdy = ($urandom_range(0, 2) != 0);
      step(req, rdy);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      checks++;
      if ($countones(bus.grant) > 1) begin
        errors++; $display("FAIL random_onehot%0d: grant %b expected at most one bit", i, bus.grant);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_rotation();
    test_backpressure();
    test_collision();
    test_illegal();
`ifdef RR_GRANT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
